// File: rtl/zb_pkg.sv
// Shared definitions for the ID-stage zero-compare branch controller:
// FSM states, busA forwarding encodings and branch-type priority encoding.
package zb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BGEZ = 3'd1,
        BR_BGTZ = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BLTZ = 3'd4
    } br_type_e;

    // Several decoded type bits at once resolve as bgez > bgtz > blez > bltz.
    function automatic br_type_e br_type_enc(
        input logic bgez,
        input logic bgtz,
        input logic blez,
        input logic bltz
    );
        if (bgez)      return BR_BGEZ;
        else if (bgtz) return BR_BGTZ;
        else if (blez) return BR_BLEZ;
        else if (bltz) return BR_BLTZ;
        else           return BR_NONE;
    endfunction

endpackage

// File: rtl/zb_hazard_detect.sv
// Combinational RAW-hazard classification of the branch source register
// against the EX and MEM stages: stall count and final busA select.
module zb_hazard_detect
    import zb_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       mem_regwrite,
    input  logic       mem_memread,
    input  logic [4:0] mem_rd,
    output logic [1:0] n_stall,
    output logic [1:0] sel
);

    logic ex_hit;
    logic mem_hit;

    // r0 is hard-wired zero, so it can never carry a hazard.
    assign ex_hit  = (rs != 5'd0) && ex_regwrite  && (ex_rd  == rs);
    assign mem_hit = (rs != 5'd0) && mem_regwrite && (mem_rd == rs);

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        n_stall = 2'd0;
        sel     = FWD_RF;
        if (ex_hit) begin
            if (ex_memread) begin
                n_stall = 2'd2;
                sel     = FWD_MEMWB;
            end else begin
                n_stall = 2'd1;
                sel     = FWD_EXMEM;
            end
        end else if (mem_hit) begin
            if (mem_memread) begin
                n_stall = 2'd1;
                sel     = FWD_MEMWB;
            end else begin
                n_stall = 2'd0;
                sel     = FWD_EXMEM;
            end
        end
    end

endmodule

// File: rtl/zero_branch_ctrl.sv
// Zero-compare branch sequencing: hazard stalls, busA forwarding, PC redirect.
// Optional saturating statistics counters with ZERO_BRANCH_STATS_EN.
module zero_branch_ctrl
    import zb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_bgez,
    input  logic             id_bgtz,
    input  logic             id_blez,
    input  logic             id_bltz,
    input  logic [4:0]       id_rs,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic             flush_in,
    input  logic             cond_met,
    output logic [1:0]       fwd_sel,
    output logic             stall,
    output logic             pc_src,
    output logic             flush_if,
`ifdef ZERO_BRANCH_STATS_EN
    output logic             br_busy,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_stall
`else
    output logic             br_busy
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("zero_branch_ctrl: CNT_W must be at least 1");
    end

    state_e     state_q;
    state_e     state_d;
    logic [1:0] sel_q;
    logic       latch_sel;
    logic       decision;
    br_type_e   br_type;
    logic       br_req;
    logic [1:0] hz_n;
    logic [1:0] hz_sel;

    assign br_type = br_type_enc(id_bgez, id_bgtz, id_blez, id_bltz);
    assign br_req  = id_valid && (br_type != BR_NONE) && !flush_in;

    zb_hazard_detect u_hazard (
        .rs           (id_rs),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_rd       (mem_rd),
        .n_stall      (hz_n),
        .sel          (hz_sel)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= FWD_RF;
        end else begin
            state_q <= state_d;
            if (latch_sel) begin
                sel_q <= hz_sel;
            end
        end
    end

    // Hazard inputs are only consulted in IDLE; later cycles run from sel_q.
    always_comb begin
        state_d   = state_q;
        fwd_sel   = FWD_RF;
        stall     = 1'b0;
        pc_src    = 1'b0;
        flush_if  = 1'b0;
        latch_sel = 1'b0;
        decision  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_req) begin
                    if (hz_n == 2'd0) begin
                        fwd_sel  = hz_sel;
                        pc_src   = cond_met;
                        flush_if = cond_met;
                        decision = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        latch_sel = 1'b1;
                        state_d   = (hz_n == 2'd2) ? ST_STALL : ST_RESOLVE;
                    end
                end
            end
            ST_STALL: begin
                fwd_sel = sel_q;
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    stall   = 1'b1;
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                fwd_sel = sel_q;
                state_d = ST_IDLE;
                if (!flush_in) begin
                    pc_src   = cond_met;
                    flush_if = cond_met;
                    decision = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign br_busy = (state_q != ST_IDLE);

`ifdef ZERO_BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br    <= '0;
            stat_taken <= '0;
            stat_stall <= '0;
        end else if (!flush_in) begin
            if (decision && (stat_br != CNT_MAX)) begin
                stat_br <= stat_br + 1'b1;
            end
            if (decision && cond_met && (stat_taken != CNT_MAX)) begin
                stat_taken <= stat_taken + 1'b1;
            end
            if (stall && (stat_stall != CNT_MAX)) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`else
    logic unused_decision;
    assign unused_decision = decision;
`endif

endmodule

// File: tb/tb_zero_branch_ctrl.sv
// Self-checking bench for zero_branch_ctrl: vector table, directed multi-cycle
// sequences and random traffic against a cycle-countdown reference model.
module tb_zero_branch_ctrl;

`ifdef ZERO_BRANCH_STATS_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] stat_br, stat_taken, stat_stall;
`else
    localparam int CNT_W = 16;
`endif

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_bgez, id_bgtz, id_blez, id_bltz;
    logic [4:0] id_rs;
    logic       ex_regwrite, ex_memread;
    logic [4:0] ex_rd;
    logic       mem_regwrite, mem_memread;
    logic [4:0] mem_rd;
    logic       flush_in;
    logic       cond_met;
    logic [1:0] fwd_sel;
    logic       stall, pc_src, flush_if, br_busy;

    int checks = 0;
    int errors = 0;

    zero_branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_bgez      (id_bgez),
        .id_bgtz      (id_bgtz),
        .id_blez      (id_blez),
        .id_bltz      (id_bltz),
        .id_rs        (id_rs),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_rd       (mem_rd),
        .flush_in     (flush_in),
        .cond_met     (cond_met),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .pc_src       (pc_src),
        .flush_if     (flush_if),
`ifdef ZERO_BRANCH_STATS_EN
        .br_busy      (br_busy),
        .stat_br      (stat_br),
        .stat_taken   (stat_taken),
        .stat_stall   (stat_stall)
`else
        .br_busy      (br_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_fwd, input logic e_stall,
                              input logic e_pc, input logic e_busy);
        check({tag, ".fwd_sel"},  fwd_sel,  e_fwd);
        check({tag, ".stall"},    stall,    e_stall);
        check({tag, ".pc_src"},   pc_src,   e_pc);
        check({tag, ".flush_if"}, flush_if, e_pc);
        check({tag, ".br_busy"},  br_busy,  e_busy);
    endtask

    task automatic drive(input logic v, input logic [3:0] ty, input logic [4:0] rs,
                         input logic exw, input logic exl, input logic [4:0] exrd,
                         input logic memw, input logic meml, input logic [4:0] memrd,
                         input logic fl, input logic cond);
        id_valid     = v;
        {id_bgez, id_bgtz, id_blez, id_bltz} = ty;
        id_rs        = rs;
        ex_regwrite  = exw;
        ex_memread   = exl;
        ex_rd        = exrd;
        mem_regwrite = memw;
        mem_memread  = meml;
        mem_rd       = memrd;
        flush_in     = fl;
        cond_met     = cond;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Reference model: cycles left until the decision (-1 = no branch in flight).
    int         m_pend = -1;
    logic [1:0] m_sel  = 2'd0;
    int         m_br = 0, m_tk = 0, m_st = 0;
    localparam int SAT = (1 << CNT_W) - 1;

    function automatic void classify(output int n, output logic [1:0] s);
        n = 0;
        s = 2'd0;
        if (id_rs != 5'd0) begin
            if (ex_regwrite && ex_rd == id_rs) begin
                n = ex_memread ? 2 : 1;
                s = ex_memread ? 2'd2 : 2'd1;
            end else if (mem_regwrite && mem_rd == id_rs) begin
                n = mem_memread ? 1 : 0;
                s = mem_memread ? 2'd2 : 2'd1;
            end
        end
    endfunction

    // Inputs must already be driven (at posedge+1); checks, advances model, waits a cycle.
    task automatic step(input string tag);
        logic [1:0] e_fwd, s;
        logic       e_stall, e_pc, e_busy;
        bit         req, dec;
        int         n;
        e_fwd = 2'd0; e_stall = 1'b0; e_pc = 1'b0; dec = 1'b0; n = 0; s = 2'd0;
        e_busy = (m_pend >= 0);
        req = id_valid && (id_bgez || id_bgtz || id_blez || id_bltz) && !flush_in;
        if (m_pend < 0) begin
            if (req) begin
                classify(n, s);
                if (n == 0) begin
                    e_fwd = s; e_pc = cond_met; dec = 1'b1;
                end else begin
                    e_stall = 1'b1;
                end
            end
        end else begin
            e_fwd = m_sel;
            if (!flush_in) begin
                if (m_pend > 1) e_stall = 1'b1;
                else begin
                    e_pc = cond_met; dec = 1'b1;
                end
            end
        end
        #2;
        if (!rst) check_outs(tag, e_fwd, e_stall, e_pc, e_busy);
        if (rst) begin
            m_pend = -1; m_sel = 2'd0; m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            if (dec && m_br < SAT) m_br++;
            if (dec && cond_met && m_tk < SAT) m_tk++;
            if (e_stall && m_st < SAT) m_st++;
            if (m_pend < 0) begin
                if (req && n > 0) begin
                    m_pend = n; m_sel = s;
                end
            end else if (flush_in || m_pend <= 1) begin
                m_pend = -1;
            end else begin
                m_pend--;
            end
        end
        @(posedge clk);
        #1;
`ifdef ZERO_BRANCH_STATS_EN
        check({tag, ".stat_br"},    stat_br,    m_br);
        check({tag, ".stat_taken"}, stat_taken, m_tk);
        check({tag, ".stat_stall"}, stat_stall, m_st);
`endif
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] ty;
        logic [4:0] rs;
        logic       exw, exl;
        logic [4:0] exrd;
        logic       memw, meml;
        logic [4:0] memrd;
        logic       fl, cond;
        logic [1:0] e_fwd;
        logic       e_stall, e_pc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // {v, type(bgez,bgtz,blez,bltz), rs, exw, exl, exrd, memw, meml, memrd, flush, cond, fwd, stall, pc}
        vecs[0]  = '{1, 4'b1000, 5, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 1};
        vecs[1]  = '{1, 4'b0100, 5, 1, 0, 5, 0, 0, 0, 0, 1, 2'd0, 1, 0};
        vecs[2]  = '{1, 4'b0001, 7, 1, 1, 7, 0, 0, 0, 0, 1, 2'd0, 1, 0};
        vecs[3]  = '{1, 4'b0010, 3, 1, 0, 3, 1, 0, 3, 0, 1, 2'd0, 1, 0};
        vecs[4]  = '{1, 4'b0010, 0, 1, 1, 0, 1, 1, 0, 0, 1, 2'd0, 0, 1};
        vecs[5]  = '{1, 4'b1000, 9, 0, 0, 0, 1, 0, 9, 0, 1, 2'd1, 0, 1};
        vecs[6]  = '{1, 4'b1000, 9, 0, 0, 0, 1, 1, 9, 0, 1, 2'd0, 1, 0};
        vecs[7]  = '{1, 4'b0100, 4, 0, 0, 4, 1, 0, 4, 0, 0, 2'd1, 0, 0};
        vecs[8]  = '{0, 4'b1000, 5, 1, 0, 5, 0, 0, 0, 0, 1, 2'd0, 0, 0};
        vecs[9]  = '{1, 4'b1000, 5, 1, 1, 5, 0, 0, 0, 1, 1, 2'd0, 0, 0};
        vecs[10] = '{1, 4'b1111, 2, 0, 0, 2, 0, 0, 2, 0, 1, 2'd0, 0, 1};
        vecs[11] = '{1, 4'b0000, 5, 1, 0, 5, 0, 0, 0, 0, 1, 2'd0, 0, 0};
        vecs[12] = '{1, 4'b0001, 6, 0, 1, 6, 0, 1, 6, 0, 0, 2'd0, 0, 0};

        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();
        #1;
        check_outs("reset_state", 2'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].ty, vecs[i].rs, vecs[i].exw, vecs[i].exl, vecs[i].exrd,
                  vecs[i].memw, vecs[i].meml, vecs[i].memrd, vecs[i].fl, vecs[i].cond);
            #2;
            check_outs($sformatf("vec%0d", i), vecs[i].e_fwd, vecs[i].e_stall, vecs[i].e_pc, 1'b0);
            @(posedge clk);
            #1;
            do_reset();
        end

        // EX ALU hazard: one stall, then resolve from EX/MEM with cond_met=0.
        drive(1, 4'b0100, 5, 1, 0, 5, 0, 0, 0, 0, 1);
        step("alu_haz.t0");
        drive(1, 4'b0100, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_outs("alu_haz.t1", 2'd1, 1'b0, 1'b0, 1'b1);
        step("alu_haz.t1m");

        // EX load: two stalls, decide from MEM/WB; hazard inputs change meanwhile.
        drive(1, 4'b0001, 7, 1, 1, 7, 0, 0, 0, 0, 1);
        step("load_haz.t0");
        drive(1, 4'b0001, 7, 0, 0, 0, 1, 1, 7, 0, 1);
        #1;
        check_outs("load_haz.t1", 2'd2, 1'b1, 1'b0, 1'b1);
        step("load_haz.t1m");
        drive(1, 4'b0001, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_outs("load_haz.t2", 2'd2, 1'b0, 1'b0, 1'b1);
        step("load_haz.t2m");

        // EX precedence over MEM, then back-to-back taken branch right after resolve.
        drive(1, 4'b0010, 3, 1, 0, 3, 1, 1, 3, 0, 1);
        step("prec.t0");
        drive(1, 4'b0010, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_outs("prec.t1", 2'd1, 1'b0, 1'b1, 1'b1);
        step("prec.t1m");
        drive(1, 4'b1000, 8, 0, 0, 0, 1, 0, 8, 0, 1);
        #1;
        check_outs("b2b", 2'd1, 1'b0, 1'b1, 1'b0);
        step("b2b.m");

        // flush_in while stalled: no decision, back to IDLE.
        drive(1, 4'b0001, 7, 1, 1, 7, 0, 0, 0, 0, 1);
        step("flush_stall.t0");
        drive(1, 4'b0001, 7, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        check({"flush_stall.t1", ".stall"},  stall,  1'b0);
        check({"flush_stall.t1", ".pc_src"}, pc_src, 1'b0);
        step("flush_stall.t1m");
        idle();
        #1;
        check_outs("flush_stall.t2", 2'd0, 1'b0, 1'b0, 1'b0);
        step("flush_stall.t2m");

        // Reset while stalled.
        drive(1, 4'b0001, 7, 1, 1, 7, 0, 0, 0, 0, 1);
        step("rst_stall.t0");
        drive(1, 4'b0001, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        step("rst_stall.t1");
        rst = 1'b0;
        idle();
        #1;
        check_outs("rst_stall.t2", 2'd0, 1'b0, 1'b0, 1'b0);
        step("rst_stall.t2m");

`ifdef ZERO_BRANCH_STATS_EN
        do_reset();
        drive(1, 4'b1000, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        step("st.b0");
        drive(1, 4'b0100, 5, 1, 0, 5, 0, 0, 0, 0, 0);
        step("st.b1a");
        step("st.b1b");
        drive(1, 4'b0001, 6, 1, 1, 6, 0, 0, 0, 0, 0);
        step("st.b2a");
        step("st.b2b");
        step("st.b2c");
        idle();
        step("st.idle");
        check("stats3.br",    stat_br,    3);
        check("stats3.taken", stat_taken, 1);
        check("stats3.stall", stat_stall, 3);
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'b0001, 6, 1, 1, 6, 0, 0, 0, 0, 0);
            step("st.sat_a");
            step("st.sat_b");
            step("st.sat_c");
        end
        check("stats_sat.stall", stat_stall, SAT);
`endif

        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 63) == 0);
            step($sformatf("rnd%0d", i));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
